// File: rtl/draw_pixel_writer.sv
// draw_pixel_writer: clips the drawer's signed pixel stream, converts each visible pixel
// into a masked 16-bit VRAM word write (4 nibble pixels per word) and queues the writes
// in a small FIFO toward the VRAM arbiter.
// Optional feature: define DRAW_COALESCE_EN to merge same-word, same-color pixels into
// one write; otherwise every visible pixel becomes its own single-nibble write.
module draw_pixel_writer #(
    parameter int unsigned CORDW      = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_i,
    input  logic [15:0]             base_i,
    input  logic [15:0]             stride_i,
    input  logic signed [CORDW-1:0] clip_x0_i,
    input  logic signed [CORDW-1:0] clip_y0_i,
    input  logic signed [CORDW-1:0] clip_x1_i,
    input  logic signed [CORDW-1:0] clip_y1_i,
    input  logic [3:0]              color_i,
    input  logic                    pix_valid_i,
    input  logic signed [CORDW-1:0] pix_x_i,
    input  logic signed [CORDW-1:0] pix_y_i,
    input  logic                    flush_i,
    output logic                    pix_ready_o,
    output logic                    vram_wr_o,
    output logic [15:0]             vram_addr_o,
    output logic [15:0]             vram_data_o,
    output logic [3:0]              vram_mask_o,
    input  logic                    vram_ack_i,
    output logic                    busy_o
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e state_q, state_d;

    // S1 stage
    logic                    s1_valid_q, s1_valid_d;
    logic [15:0]             s1_row_q, s1_row_d;
    logic signed [CORDW-1:0] s1_x_q, s1_x_d;
    logic [3:0]              s1_color_q, s1_color_d;

    // S2 / coalesce stage
    logic        c_valid_q, c_valid_d;
    logic [15:0] c_addr_q, c_addr_d;
    logic [3:0]  c_mask_q, c_mask_d;
    logic [3:0]  c_color_q, c_color_d;

    // Write FIFO
    logic [15:0]     addr_mem [FIFO_DEPTH];
    logic [3:0]      mask_mem [FIFO_DEPTH];
    logic [3:0]      color_mem[FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic                    accept, in_clip;
    logic                    push_req, fifo_push, fifo_pop, fifo_full, stall;
    logic [15:0]             y16, new_addr;
    logic [3:0]              new_mask;
    logic signed [CORDW-1:0] x_word;

    assign y16       = pix_y_i[15:0];
    assign x_word    = s1_x_q >>> 2;
    assign new_addr  = base_i + s1_row_q + x_word[15:0];
    assign new_mask  = 4'b1000 >> s1_x_q[1:0];
    assign fifo_full = (count_q == CntW'(FIFO_DEPTH));
    assign fifo_pop  = vram_wr_o && vram_ack_i;

    // Two free entries cover the pixel that may still be in S1 when the FIFO fills.
    assign pix_ready_o = ((CntW'(FIFO_DEPTH) - count_q) >= CntW'(2));
    assign accept      = pix_valid_i && pix_ready_o;
    assign in_clip     = (pix_x_i >= clip_x0_i) && (pix_x_i <= clip_x1_i) &&
                         (pix_y_i >= clip_y0_i) && (pix_y_i <= clip_y1_i);

    // Coalesce stage: decide push/merge/load; a push into a full FIFO stalls S1 and S2.
    always_comb begin
        c_valid_d = c_valid_q;
        c_addr_d  = c_addr_q;
        c_mask_d  = c_mask_q;
        c_color_d = c_color_q;
        push_req  = 1'b0;
`ifdef DRAW_COALESCE_EN
        if (s1_valid_q) begin
            if (!(c_valid_q && new_addr == c_addr_q && s1_color_q == c_color_q)) begin
                push_req = c_valid_q;
            end
        end else if (state_q == StDrain) begin
            push_req = c_valid_q;
        end
`else
        push_req = c_valid_q;
`endif
        fifo_push = push_req && !(fifo_full && !fifo_pop);
        stall     = push_req && !fifo_push;
`ifdef DRAW_COALESCE_EN
        if (s1_valid_q && c_valid_q && new_addr == c_addr_q && s1_color_q == c_color_q) begin
            c_mask_d = c_mask_q | new_mask;
        end else if (s1_valid_q && !stall) begin
            c_valid_d = 1'b1;
            c_addr_d  = new_addr;
            c_mask_d  = new_mask;
            c_color_d = s1_color_q;
        end else if (fifo_push) begin
            c_valid_d = 1'b0;
        end
`else
        if (!stall) begin
            c_valid_d = s1_valid_q;
            c_addr_d  = new_addr;
            c_mask_d  = new_mask;
            c_color_d = s1_color_q;
        end
`endif
    end

    // S1: clip test and row multiply; clipped pixels are consumed without a valid slot.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_row_d   = s1_row_q;
        s1_x_d     = s1_x_q;
        s1_color_d = s1_color_q;
        if (!stall) begin
            s1_valid_d = accept && in_clip;
            if (accept) begin
                s1_row_d   = y16 * stride_i;
                s1_x_d     = pix_x_i;
                s1_color_d = color_i;
            end
        end
    end

    // Flush FSM and FIFO pointer/count next state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (flush_i) state_d = StDrain;
            StDrain: if (!s1_valid_q && (!c_valid_q || fifo_push)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
        wr_ptr_d = fifo_push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = fifo_pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (fifo_push && !fifo_pop) count_d = count_q + CntW'(1);
        if (!fifo_push && fifo_pop) count_d = count_q - CntW'(1);
    end

    // Pipeline, FSM and FIFO control state; reset discards everything in flight.
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            s1_valid_q <= 1'b0;
            s1_row_q   <= '0;
            s1_x_q     <= '0;
            s1_color_q <= '0;
            c_valid_q  <= 1'b0;
            c_addr_q   <= '0;
            c_mask_q   <= '0;
            c_color_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            s1_valid_q <= s1_valid_d;
            s1_row_q   <= s1_row_d;
            s1_x_q     <= s1_x_d;
            s1_color_q <= s1_color_d;
            c_valid_q  <= c_valid_d;
            c_addr_q   <= c_addr_d;
            c_mask_q   <= c_mask_d;
            c_color_q  <= c_color_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            addr_mem[wr_ptr_q]  <= c_addr_q;
            mask_mem[wr_ptr_q]  <= c_mask_q;
            color_mem[wr_ptr_q] <= c_color_q;
        end
    end

    assign vram_wr_o   = (count_q != '0);
    assign vram_addr_o = vram_wr_o ? addr_mem[rd_ptr_q] : 16'h0000;
    assign vram_data_o = vram_wr_o ? {4{color_mem[rd_ptr_q]}} : 16'h0000;
    assign vram_mask_o = vram_wr_o ? mask_mem[rd_ptr_q] : 4'b0000;
    assign busy_o      = s1_valid_q || c_valid_q || vram_wr_o || (state_q != StIdle);

endmodule
